// File: rtl/cpu_dcache_arbiter_if.sv
// Request/response bundle between the two data-cache masters, the arbiter
// and the data cache request port. The arbiter uses the slave view; the
// environment (CPU side plus cache) uses the master view.
interface cpu_dcache_arbiter_if;
  // port A (load/store unit)
  logic        i_a_request;
  logic        i_a_rw;
  logic        i_a_flush;
  logic        i_a_cacheable;
  logic        i_a_lock;
  logic [31:0] i_a_address;
  logic [31:0] i_a_wdata;
  logic        o_a_ready;
  logic [31:0] o_a_rdata;
  // port B (debug / DMA / atomic unit)
  logic        i_b_request;
  logic        i_b_rw;
  logic        i_b_flush;
  logic        i_b_cacheable;
  logic        i_b_lock;
  logic [31:0] i_b_address;
  logic [31:0] i_b_wdata;
  logic        o_b_ready;
  logic [31:0] o_b_rdata;
  // data cache request port
  logic        o_dc_request;
  logic        o_dc_rw;
  logic        o_dc_flush;
  logic        o_dc_cacheable;
  logic [31:0] o_dc_address;
  logic [31:0] o_dc_wdata;
  logic        i_dc_ready;
  logic [31:0] i_dc_rdata;

  modport slave (
    input  i_a_request, i_a_rw, i_a_flush, i_a_cacheable, i_a_lock,
    input  i_a_address, i_a_wdata,
    output o_a_ready, o_a_rdata,
    input  i_b_request, i_b_rw, i_b_flush, i_b_cacheable, i_b_lock,
    input  i_b_address, i_b_wdata,
    output o_b_ready, o_b_rdata,
    output o_dc_request, o_dc_rw, o_dc_flush, o_dc_cacheable,
    output o_dc_address, o_dc_wdata,
    input  i_dc_ready, i_dc_rdata
  );

  modport master (
    output i_a_request, i_a_rw, i_a_flush, i_a_cacheable, i_a_lock,
    output i_a_address, i_a_wdata,
    input  o_a_ready, o_a_rdata,
    output i_b_request, i_b_rw, i_b_flush, i_b_cacheable, i_b_lock,
    output i_b_address, i_b_wdata,
    input  o_b_ready, o_b_rdata,
    input  o_dc_request, o_dc_rw, o_dc_flush, o_dc_cacheable,
    input  o_dc_address, o_dc_wdata,
    output i_dc_ready, i_dc_rdata
  );
endinterface

// File: rtl/cpu_dcache_arbiter.sv
// Two-port arbiter in front of the data cache request port. Transactions
// are serialized with round-robin fairness; an owner may keep the grant
// across transactions (lock) for a bounded number of idle cycles so that
// read-modify-write sequences are not interleaved with the other port.
module cpu_dcache_arbiter #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  cpu_dcache_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  // last lock_count value before the locked owner is forced to let go
  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  // Per-port views indexed by port number (0 = A, 1 = B)
  logic [1:0]       port_request;
  logic [1:0]       port_rw;
  logic [1:0]       port_flush;
  logic [1:0]       port_cacheable;
  logic [1:0]       port_lock;
  logic [1:0][31:0] port_address;
  logic [1:0][31:0] port_wdata;

  assign port_request   = {bus.i_b_request,   bus.i_a_request};
  assign port_rw        = {bus.i_b_rw,        bus.i_a_rw};
  assign port_flush     = {bus.i_b_flush,     bus.i_a_flush};
  assign port_cacheable = {bus.i_b_cacheable, bus.i_a_cacheable};
  assign port_lock      = {bus.i_b_lock,      bus.i_a_lock};
  assign port_address   = {bus.i_b_address,   bus.i_a_address};
  assign port_wdata     = {bus.i_b_wdata,     bus.i_a_wdata};

  state_t           state_reg,        state_next;
  logic             owner_reg,        owner_next;
  logic             last_grant_reg,   last_grant_next;
  logic             lock_hold_reg,    lock_hold_next;
  logic [7:0]       lock_count_reg,   lock_count_next;
  logic             dc_request_reg,   dc_request_next;
  logic             dc_rw_reg,        dc_rw_next;
  logic             dc_flush_reg,     dc_flush_next;
  logic             dc_cacheable_reg, dc_cacheable_next;
  logic [31:0]      dc_address_reg,   dc_address_next;
  logic [31:0]      dc_wdata_reg,     dc_wdata_next;
  logic [1:0]       ready_reg,        ready_next;
  logic [1:0][31:0] rdata_reg,        rdata_next;

  // port selected for a new issue this cycle, and whether one happens
  logic             grant;
  logic             issue;

  // Next-state, grant selection and registered-output updates
  always_comb begin
    state_next        = state_reg;
    owner_next        = owner_reg;
    last_grant_next   = last_grant_reg;
    lock_hold_next    = lock_hold_reg;
    lock_count_next   = lock_count_reg;
    dc_request_next   = dc_request_reg;
    dc_rw_next        = dc_rw_reg;
    dc_flush_next     = dc_flush_reg;
    dc_cacheable_next = dc_cacheable_reg;
    dc_address_next   = dc_address_reg;
    dc_wdata_next     = dc_wdata_reg;
    ready_next        = 2'b00;
    rdata_next        = rdata_reg;
    grant             = owner_reg;
    issue             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (port_request != 2'b00) begin
          // on contention the port that did not win last time goes first
          if (port_request == 2'b11) begin
            grant = ~last_grant_reg;
          end else begin
            grant = port_request[1];
          end
          issue           = 1'b1;
          owner_next      = grant;
          last_grant_next = grant;
          state_next      = BUSY;
        end
      end

      BUSY: begin
        if (bus.i_dc_ready) begin
          dc_request_next        = 1'b0;
          ready_next[owner_reg]  = 1'b1;
          rdata_next[owner_reg]  = bus.i_dc_rdata;
          lock_hold_next         = port_lock[owner_reg];
          state_next             = COMPLETE;
        end
      end

      COMPLETE: begin
        // one dead cycle lets the owner drop its request after ready
        if (lock_hold_reg) begin
          lock_count_next = 8'd0;
          state_next      = LOCKED;
        end else begin
          state_next      = IDLE;
        end
      end

      LOCKED: begin
        if (port_request[owner_reg]) begin
          // locked follow-up does not count as a new round-robin grant
          grant      = owner_reg;
          issue      = 1'b1;
          state_next = BUSY;
        end else if (!port_lock[owner_reg] || (lock_count_reg == LOCK_LAST)) begin
          state_next = IDLE;
        end else begin
          lock_count_next = lock_count_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (issue) begin
      dc_request_next   = 1'b1;
      dc_rw_next        = port_rw[grant];
      dc_flush_next     = port_flush[grant];
      dc_cacheable_next = port_cacheable[grant];
      dc_address_next   = port_address[grant];
      dc_wdata_next     = port_wdata[grant];
    end
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg        <= IDLE;
      owner_reg        <= 1'b0;
      last_grant_reg   <= 1'b1;
      lock_hold_reg    <= 1'b0;
      lock_count_reg   <= 8'd0;
      dc_request_reg   <= 1'b0;
      dc_rw_reg        <= 1'b0;
      dc_flush_reg     <= 1'b0;
      dc_cacheable_reg <= 1'b0;
      dc_address_reg   <= 32'd0;
      dc_wdata_reg     <= 32'd0;
      ready_reg        <= 2'b00;
      rdata_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      owner_reg        <= owner_next;
      last_grant_reg   <= last_grant_next;
      lock_hold_reg    <= lock_hold_next;
      lock_count_reg   <= lock_count_next;
      dc_request_reg   <= dc_request_next;
      dc_rw_reg        <= dc_rw_next;
      dc_flush_reg     <= dc_flush_next;
      dc_cacheable_reg <= dc_cacheable_next;
      dc_address_reg   <= dc_address_next;
      dc_wdata_reg     <= dc_wdata_next;
      ready_reg        <= ready_next;
      rdata_reg        <= rdata_next;
    end
  end

  assign bus.o_dc_request   = dc_request_reg;
  assign bus.o_dc_rw        = dc_rw_reg;
  assign bus.o_dc_flush     = dc_flush_reg;
  assign bus.o_dc_cacheable = dc_cacheable_reg;
  assign bus.o_dc_address   = dc_address_reg;
  assign bus.o_dc_wdata     = dc_wdata_reg;
  assign bus.o_a_ready      = ready_reg[0];
  assign bus.o_b_ready      = ready_reg[1];
  assign bus.o_a_rdata      = rdata_reg[0];
  assign bus.o_b_rdata      = rdata_reg[1];

endmodule

// File: tb/tb_cpu_dcache_arbiter.sv
// Scoreboard bench for cpu_dcache_arbiter: requesters push the expected
// cache-side issue order, a monitor pops and checks each issue and each
// completion pulse, and a simple cache model answers after a fixed latency.
module tb_cpu_dcache_arbiter;

  logic i_clock;
  logic i_reset;

  cpu_dcache_arbiter_if bus ();

  cpu_dcache_arbiter #(.MAX_LOCK(4)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    bit          port;
    bit          rw;
    bit          flush;
    bit          cacheable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb_q[$];
  txn_t cur;
  bit   have_cur;
  int   total = 0;
  int   bad   = 0;
  int   b_ready_seen = 0;
  int   lat = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // data the cache model returns for an address
  function automatic logic [31:0] data_for(input logic [31:0] addr);
    if (addr == 32'h40) return 32'h1234_5678;
    return {addr[15:0] ^ 16'hBEEF, addr[15:0]};
  endfunction

  function automatic void expect_txn(input bit port, input bit rw, input bit flush,
                                     input bit cacheable, input logic [31:0] addr,
                                     input logic [31:0] wdata);
    txn_t t;
    t.port = port; t.rw = rw; t.flush = flush; t.cacheable = cacheable;
    t.addr = addr; t.wdata = wdata; t.rdata = data_for(addr);
    sb_q.push_back(t);
  endfunction

  // Cache model: answers lat cycles after the request is seen, one-cycle ready
  initial begin
    int cnt;
    cnt = 0;
    bus.i_dc_ready = 1'b0;
    bus.i_dc_rdata = 32'd0;
    forever begin
      @(posedge i_clock);
      #2;
      if (i_reset) begin
        bus.i_dc_ready = 1'b0;
        cnt = 0;
      end else if (bus.i_dc_ready) begin
        bus.i_dc_ready = 1'b0;
        cnt = 0;
      end else if (bus.o_dc_request) begin
        cnt++;
        if (cnt >= lat) begin
          bus.i_dc_ready = 1'b1;
          bus.i_dc_rdata = data_for(bus.o_dc_address);
        end
      end
    end
  end

  // Monitor: checks issues against the scoreboard and each ready pulse
  initial begin
    bit prev_req;
    bit prev_dcr;
    prev_req = 1'b0;
    prev_dcr = 1'b0;
    have_cur = 1'b0;
    forever begin
      @(posedge i_clock);
      #3;
      if (i_reset) begin
        prev_req = 1'b0;
        prev_dcr = 1'b0;
        have_cur = 1'b0;
        continue;
      end
      chk("req_after_dc_ready", {31'd0, bus.o_dc_request & prev_dcr}, 32'd0);
      if (bus.o_dc_request && !prev_req) begin
        chk("issue_expected", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          cur = sb_q.pop_front();
          have_cur = 1'b1;
          chk("issue_rw",        {31'd0, bus.o_dc_rw},        {31'd0, cur.rw});
          chk("issue_flush",     {31'd0, bus.o_dc_flush},     {31'd0, cur.flush});
          chk("issue_cacheable", {31'd0, bus.o_dc_cacheable}, {31'd0, cur.cacheable});
          chk("issue_addr",      bus.o_dc_address,            cur.addr);
          chk("issue_wdata",     bus.o_dc_wdata,              cur.wdata);
        end
      end else if (bus.o_dc_request && have_cur) begin
        chk("busy_addr_stable", bus.o_dc_address, cur.addr);
      end
      if (bus.o_b_ready) b_ready_seen++;
      if (bus.o_a_ready || bus.o_b_ready) begin
        chk("ready_expected", {31'd0, have_cur}, 32'd1);
        chk("ready_timing",   {31'd0, prev_dcr}, 32'd1);
        chk("ready_onehot",   {31'd0, bus.o_a_ready & bus.o_b_ready}, 32'd0);
        if (have_cur) begin
          chk("ready_port",  {31'd0, bus.o_b_ready}, {31'd0, cur.port});
          chk("ready_rdata", bus.o_b_ready ? bus.o_b_rdata : bus.o_a_rdata, cur.rdata);
          $display("txn port=%s rw=%0d flush=%0d addr=%h rdata=%h",
                   cur.port ? "B" : "A", cur.rw, cur.flush, cur.addr,
                   bus.o_b_ready ? bus.o_b_rdata : bus.o_a_rdata);
          have_cur = 1'b0;
        end
      end
      prev_req = bus.o_dc_request;
      prev_dcr = bus.i_dc_ready;
    end
  end

  // One requester transaction: raise request, wait for own ready, drop request
  task automatic do_req(input bit port, input bit rw, input bit flush, input bit cacheable,
                        input bit lock, input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    if (port) begin
      bus.i_b_rw = rw; bus.i_b_flush = flush; bus.i_b_cacheable = cacheable;
      bus.i_b_lock = lock; bus.i_b_address = addr; bus.i_b_wdata = wdata;
      bus.i_b_request = 1'b1;
    end else begin
      bus.i_a_rw = rw; bus.i_a_flush = flush; bus.i_a_cacheable = cacheable;
      bus.i_a_lock = lock; bus.i_a_address = addr; bus.i_a_wdata = wdata;
      bus.i_a_request = 1'b1;
    end
    for (int n = 0; n < 200; n++) begin
      @(posedge i_clock);
      #1;
      if (port ? bus.o_b_ready : bus.o_a_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (port) bus.i_b_request = 1'b0;
    else      bus.i_a_request = 1'b0;
    chk(port ? "b_req_timeout" : "a_req_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    int b_before;
    int n;
    i_reset = 1'b1;
    bus.i_a_request = 0; bus.i_a_rw = 0; bus.i_a_flush = 0; bus.i_a_cacheable = 0;
    bus.i_a_lock = 0; bus.i_a_address = 0; bus.i_a_wdata = 0;
    bus.i_b_request = 0; bus.i_b_rw = 0; bus.i_b_flush = 0; bus.i_b_cacheable = 0;
    bus.i_b_lock = 0; bus.i_b_address = 0; bus.i_b_wdata = 0;

    // reset state
    repeat (3) @(posedge i_clock);
    #3;
    chk("rst_dc_request", {31'd0, bus.o_dc_request}, 32'd0);
    chk("rst_dc_address", bus.o_dc_address, 32'd0);
    chk("rst_a_ready",    {31'd0, bus.o_a_ready}, 32'd0);
    chk("rst_b_ready",    {31'd0, bus.o_b_ready}, 32'd0);
    chk("rst_a_rdata",    bus.o_a_rdata, 32'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;

    // single A read: request visible one cycle later, B never acknowledged
    b_before = b_ready_seen;
    expect_txn(0, 0, 0, 1, 32'h40, 32'h0);
    fork
      do_req(0, 0, 0, 1, 0, 32'h40, 32'h0);
      begin
        #2;
        chk("t1_req_before", {31'd0, bus.o_dc_request}, 32'd0);
        @(posedge i_clock);
        #3;
        chk("t1_req_latency", {31'd0, bus.o_dc_request}, 32'd1);
      end
    join
    gap(2);
    chk("t1_no_b_ready", b_ready_seen - b_before, 32'd0);

    // contention from reset: A first, then alternation follows last grant
    do_reset();
    expect_txn(0, 0, 0, 1, 32'h10, 32'h0);
    expect_txn(1, 1, 0, 1, 32'h20, 32'hCAFE_0001);
    fork
      do_req(0, 0, 0, 1, 0, 32'h10, 32'h0);
      do_req(1, 1, 0, 1, 0, 32'h20, 32'hCAFE_0001);
    join
    gap(2);
    expect_txn(0, 1, 0, 1, 32'h14, 32'h0000_0014);
    expect_txn(1, 0, 0, 0, 32'h24, 32'h0);
    fork
      do_req(0, 1, 0, 1, 0, 32'h14, 32'h0000_0014);
      do_req(1, 0, 0, 0, 0, 32'h24, 32'h0);
    join
    gap(2);
    expect_txn(0, 0, 0, 1, 32'h18, 32'h0);
    do_req(0, 0, 0, 1, 0, 32'h18, 32'h0);
    gap(2);
    expect_txn(1, 0, 0, 1, 32'h28, 32'h0);
    expect_txn(0, 0, 0, 1, 32'h1C, 32'h0);
    fork
      do_req(0, 0, 0, 1, 0, 32'h1C, 32'h0);
      do_req(1, 0, 0, 1, 0, 32'h28, 32'h0);
    join
    gap(2);

    // locked read-modify-write from A holds off a continuously requesting B
    expect_txn(0, 0, 0, 1, 32'h100, 32'h0);
    expect_txn(0, 1, 0, 1, 32'h100, 32'hDEAD_BEEF);
    expect_txn(1, 0, 0, 1, 32'h300, 32'h0);
    fork
      begin
        do_req(0, 0, 0, 1, 1, 32'h100, 32'h0);
        gap(1);
        do_req(0, 1, 0, 1, 0, 32'h100, 32'hDEAD_BEEF);
      end
      begin
        gap(1);
        do_req(1, 0, 0, 1, 0, 32'h300, 32'h0);
      end
    join
    gap(2);

    // idle locked owner: forced release after 4 LOCKED cycles, then B issues
    expect_txn(0, 0, 0, 1, 32'h140, 32'h0);
    expect_txn(1, 0, 0, 1, 32'h340, 32'h0);
    fork
      begin
        do_req(0, 0, 0, 1, 1, 32'h140, 32'h0);
        n = 0;
        while (n < 50) begin
          @(posedge i_clock);
          #1;
          n++;
          if (bus.o_dc_request) break;
        end
        chk("lock_release_cycles", n, 32'd6);
      end
      begin
        gap(1);
        do_req(1, 0, 0, 1, 0, 32'h340, 32'h0);
      end
    join
    bus.i_a_lock = 1'b0;
    gap(2);

    // B flush forwarded like an ordinary transaction
    expect_txn(1, 0, 1, 0, 32'h200, 32'h0);
    do_req(1, 0, 1, 0, 0, 32'h200, 32'h0);
    gap(2);

    // reset in the middle of a BUSY transaction
    expect_txn(0, 1, 0, 1, 32'h50, 32'h5555_AAAA);
    bus.i_a_rw = 1; bus.i_a_flush = 0; bus.i_a_cacheable = 1; bus.i_a_lock = 0;
    bus.i_a_address = 32'h50; bus.i_a_wdata = 32'h5555_AAAA;
    bus.i_a_request = 1'b1;
    gap(2);
    i_reset = 1'b1;
    bus.i_a_request = 1'b0;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    #2;
    chk("mid_rst_dc_request",   {31'd0, bus.o_dc_request},   32'd0);
    chk("mid_rst_dc_address",   bus.o_dc_address,            32'd0);
    chk("mid_rst_dc_wdata",     bus.o_dc_wdata,              32'd0);
    chk("mid_rst_dc_rw",        {31'd0, bus.o_dc_rw},        32'd0);
    chk("mid_rst_dc_cacheable", {31'd0, bus.o_dc_cacheable}, 32'd0);
    chk("mid_rst_a_rdata",      bus.o_a_rdata,               32'd0);
    chk("mid_rst_b_rdata",      bus.o_b_rdata,               32'd0);
    chk("mid_rst_ready",        {30'd0, bus.o_b_ready, bus.o_a_ready}, 32'd0);
    gap(1);
    expect_txn(0, 0, 0, 1, 32'h60, 32'h0);
    expect_txn(1, 0, 0, 1, 32'h64, 32'h0);
    fork
      do_req(0, 0, 0, 1, 0, 32'h60, 32'h0);
      do_req(1, 0, 0, 1, 0, 32'h64, 32'h0);
    join
    gap(3);
    chk("scoreboard_left", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_dcache_arbiter.md
# cpu_dcache_arbiter

Two-port arbiter sharing the single request port of the data cache between the load/store unit (port A) and a secondary master (port B: debug/DMA/atomic unit). It serializes transactions with round-robin fairness and supports a bounded lock so a read-modify-write sequence from one port is not interleaved with the other. Flush requests are forwarded like ordinary transactions. It sits between the CPU memory stage and the data cache; the cache's bus side is untouched.

## Interface
- MAX_LOCK, 16: cycles an idle locked owner may hold the grant before forced release (1..255).
- i_clock  in  1  clock.
- i_reset  in  1  Synchronous, active-high reset.
- i_a_request / i_b_request  in  1  transaction request; held high until own ready pulse.
- i_a_rw / i_b_rw  in  1  1 = write.
- i_a_flush / i_b_flush  in  1  flush request (address/data ignored downstream).
- i_a_cacheable / i_b_cacheable  in  1  cacheable attribute.
- i_a_lock / i_b_lock  in  1  keep grant after this transaction completes.
- i_a_address / i_b_address  in  32  byte address.
- i_a_wdata / i_b_wdata  in  32  write data.
- o_a_ready / o_b_ready  out  1  one-cycle completion pulse.
- o_a_rdata / o_b_rdata  out  32  read data, valid with ready.
- o_dc_request, o_dc_rw, o_dc_flush, o_dc_cacheable  out  1  to cache.
- o_dc_address, o_dc_wdata  out  32  to cache.
- i_dc_ready  in  1  cache completion pulse.
- i_dc_rdata  in  32  cache read data.

## Operation
- States: IDLE, BUSY, COMPLETE, LOCKED. Registers: owner (0=A,1=B), last_grant, lock_count (8 bits).
- IDLE: if exactly one request, grant it; if both, grant port != last_grant. Latch owner's rw/flush/cacheable/address/wdata into o_dc_*, set o_dc_request=1, last_grant<=owner, -> BUSY.
- BUSY: o_dc_* held stable. On i_dc_ready: o_dc_request<=0, o_<owner>_rdata<=i_dc_rdata, o_<owner>_ready<=1, -> COMPLETE. Non-owner request is ignored (stays pending).
- COMPLETE (one cycle, gives owner time to drop request): if owner's i_x_lock was high at completion (sampled in BUSY with i_dc_ready) -> LOCKED with lock_count<=0; else -> IDLE.
- LOCKED: only owner may issue. Owner request -> latch and issue as in IDLE, -> BUSY (last_grant unchanged). Owner lock low with no request, or lock_count == MAX_LOCK-1 -> IDLE. Otherwise lock_count++.
- o_x_ready is high only in the cycle after i_dc_ready, only for owner; o_x_rdata holds last value otherwise.
- Reset (any state, including mid-BUSY): state IDLE, o_dc_request=0, all o_dc_* = 0, o_a/b_ready=0, o_a/b_rdata=0, last_grant=B (A wins first contention), lock_count=0. The cache shares i_reset and abandons its own transaction.

## Timing
- Request sampled in IDLE at cycle N -> o_dc_request high at N+1.
- i_dc_ready at cycle M -> o_x_ready high at M+1, o_dc_request low at M+1; IDLE/LOCKED at M+2.
- Requester must deassert request by M+2 (registered drop after seeing ready); arbiter samples no request in COMPLETE.
- Added latency: 2 cycles per transaction; back-to-back throughput one transaction per (cache latency + 3) cycles.
- o_dc_request never high in the cycle following i_dc_ready (cache ignores that cycle).
- Locked-idle limit: forced release after MAX_LOCK cycles in LOCKED without owner request.

## Test plan
- Single A read, cache returns 0x1234_5678 after 3 cycles -> o_dc_request high 1 cycle after request; o_a_ready pulse with rdata 0x1234_5678; o_b_ready never high.
- A and B request together from reset -> A granted first, B issued at cycle after A's COMPLETE; next simultaneous contention grants A then B again only per alternation (last_grant toggles).
- A holds lock across read 0x100 then write 0x100 while B requests continuously -> B not issued until A's write completes with lock low; then B granted.
- A locks then goes idle with lock high, MAX_LOCK=4 -> B granted exactly after 4 LOCKED cycles.
- B flush request -> o_dc_flush=1, o_dc_request until i_dc_ready; o_b_ready pulse one cycle later.
- i_reset asserted mid-BUSY -> next cycle o_dc_request=0, state IDLE, outputs zero; subsequent A+B contention grants A.
